// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - 16-word instruction store loaded from a byte stream, read by the CPU fetch path.
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [4:0]  load_len,
  input  logic        load_abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_stall,
  input  logic [15:0] pc,
  output logic [15:0] instruction
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [15:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_cnt;
  logic [4:0]        r_len;
  logic [7:0]        r_hi;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_len_ok;
  logic              w_accept;
  logic              w_last;

  assign w_len_ok = (load_len != 5'd0) && (load_len <= 5'(DEPTH));
  assign w_accept = in_valid && r_in_ready;
  assign w_last   = ({1'b0, r_cnt} == (r_len - 5'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_hi       <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 16'h0000;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            if (w_len_ok) begin
              r_len      <= load_len;
              r_cnt      <= '0;
              r_state    <= S_HI;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_HI: begin
          // Abort wins over a byte offered on the same edge.
          if (load_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            r_err      <= 1'b1;
            r_hi       <= '0;
          end else if (w_accept) begin
            r_hi    <= in_data;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (load_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            r_err      <= 1'b1;
            r_hi       <= '0;
          end else if (w_accept) begin
            r_mem[r_cnt] <= {r_hi, in_data};
            if (w_last) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_HI;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign cpu_stall = r_busy;
  assign done      = r_done;
  assign err       = r_err;

  // Fetch returns NOP while loading or when the PC is beyond the store.
  always_comb begin
    instruction = 16'h0000;
    if (!r_busy && (pc < 16'(2 * DEPTH))) instruction = r_mem[pc[ADDR_W:1]];
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against an array model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [4:0]  load_len = '0;
  logic        load_abort = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_stall;
  logic [15:0] pc = '0;
  logic [15:0] instruction;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] model_mem [16];
  logic [15:0] ld_words  [16];

  imem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .load_abort(load_abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done), .err(err),
    .cpu_stall(cpu_stall), .pc(pc), .instruction(instruction)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) begin
      pc = 16'(2 * i + $urandom_range(0, 1));
      #1;
      check(tag, instruction, model_mem[i]);
    end
    pc = 16'(32 + $urandom_range(0, 2000));
    #1;
    check({tag, "_oob"}, instruction, 16'h0000);
  endtask

  // vmode: 0 = valid always, 1 = toggling, 2 = random gaps
  task automatic do_load(input int len, input int vmode, input bit poke);
    int idx, cyc, total;
    bit acc, tog;
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 5'(len);
    @(negedge clk);
    load_start = 1'b0;
    check("start_busy", {busy, in_ready, cpu_stall}, 3'b111);
    idx = 0; cyc = 0; tog = 1'b1; total = 2 * len;
    while (idx < total && cyc < 2000) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = tog;
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      tog = ~tog;
      in_data = (idx % 2 == 0) ? ld_words[idx/2][15:8] : ld_words[idx/2][7:0];
      if (poke && idx == 1) begin
        load_start = 1'b1;
        load_len   = 5'd1;
      end else begin
        load_start = 1'b0;
      end
      pc = 16'($urandom_range(0, 31));
      #1;
      check("loading_flags", {busy, done, err}, 3'b100);
      check("instr_busy", instruction, 16'h0000);
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    check("load_timeout", (cyc < 2000), 1'b1);
    check("done_pulse", {busy, done, err, in_ready}, 4'b1100);
    @(negedge clk);
    check("after_done", {busy, done, err, cpu_stall}, 4'b0000);
    for (int i = 0; i < len; i++) model_mem[i] = ld_words[i];
  endtask

  task automatic bad_start(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 5'(len);
    @(negedge clk);
    load_start = 1'b0;
    check("bad_start_err", {err, busy, in_ready}, 3'b100);
    @(negedge clk);
    check("bad_start_clr", {err, busy}, 2'b00);
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_flags", {busy, in_ready, done, err, cpu_stall}, 5'b0);
    pc = 16'd0;  #1; check("rst_pc0", instruction, 16'h0000);
    pc = 16'd2;  #1; check("rst_pc2", instruction, 16'h0000);
    pc = 16'd30; #1; check("rst_pc30", instruction, 16'h0000);

    ld_words[0] = 16'h8080; ld_words[1] = 16'hE101;
    do_load(2, 0, 1'b0);
    pc = 16'd0; #1; check("two_w0", instruction, 16'h8080);
    pc = 16'd2; #1; check("two_w1", instruction, 16'hE101);
    pc = 16'd4; #1; check("two_w2", instruction, 16'h0000);

    ld_words[0] = 16'hC07A;
    do_load(1, 1, 1'b0);
    pc = 16'd0; #1; check("bp_w0", instruction, 16'hC07A);

    for (int i = 0; i < 16; i++) ld_words[i] = 16'(16'h0100 + i);
    do_load(16, 2, 1'b0);
    pc = 16'd30; #1; check("full_pc30", instruction, 16'h010F);
    pc = 16'd32; #1; check("full_pc32", instruction, 16'h0000);
    ld_words[0] = 16'hFFFF;
    do_load(1, 0, 1'b0);
    pc = 16'd2; #1; check("keep_w1", instruction, 16'h0101);
    check_mem("full_mem");

    bad_start(0);
    bad_start(17);
    bad_start($urandom_range(18, 31));
    for (int i = 0; i < 3; i++) ld_words[i] = 16'($urandom);
    do_load(3, 0, 1'b1);
    check_mem("poke_mem");

    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) ld_words[i] = 16'($urandom);
      do_load(len, 2, 1'b0);
      check_mem("rand_mem");
    end

    // Abort after three bytes, with a fourth byte offered on the same edge
    ld_words[0] = 16'h1234; ld_words[1] = 16'h5678; ld_words[2] = 16'h9ABC;
    @(negedge clk);
    load_start = 1'b1; load_len = 5'd3;
    @(negedge clk);
    load_start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h12; @(negedge clk);
    in_data = 8'h34; @(negedge clk);
    in_data = 8'h56; @(negedge clk);
    in_data = 8'h78; load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0; in_valid = 1'b0;
    check("abort_err", {err, busy, in_ready, done}, 4'b1000);
    @(negedge clk);
    check("abort_clr", {err, busy}, 2'b00);
    model_mem[0] = 16'h1234;
    check_mem("abort_mem");

    // Reset between edges while loading
    @(negedge clk);
    load_start = 1'b1; load_len = 5'd4;
    @(negedge clk);
    load_start = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    in_data = 8'hBB;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_flags", {busy, in_ready, done, err, cpu_stall}, 5'b0);
    pc = 16'd0; #1; check("rst_mid_pc0", instruction, 16'h0000);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    check_mem("rst_mid_mem");
    @(negedge clk);
    check("rst_mid_quiet", {busy, done, err}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writable instruction store with a serial program-load port.
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words high byte first, and writes them sequentially into a 16-word array.
- Serves the same array to the CPU fetch path: byte-addressed PC in, 16-bit instruction out.
- Holds the CPU in stall while a load is in progress.

Parameters:
- DEPTH, 16, number of 16-bit instruction words stored.
- ADDR_W, 4, word-address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- load_start  input  1  single-cycle pulse; begins a load of load_len words at word 0.
- load_len  input  5  number of words to load, 1..16; sampled when load_start is accepted.
- load_abort  input  1  terminates an in-progress load.
- in_data  input  8  program byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- busy  output  1  a load is in progress.
- done  output  1  single-cycle pulse when the last word of a load is written.
- err  output  1  single-cycle pulse on an illegal start or an abort.
- cpu_stall  output  1  CPU must hold its PC; equals busy.
- pc  input  16  byte address from the CPU.
- instruction  output  16  fetched instruction word.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - in_ready, busy, done, err and cpu_stall = 0.
  - Word counter and high-byte holding register = 0.
  - All DEPTH memory words = 16'h0000, which is a NOP.
- Handshake: a byte is accepted on a rising edge only when in_valid && in_ready. in_ready is 1 only in states HI and LO. in_data is not sampled otherwise.
- State machine:
  - IDLE:
    - load_start with load_len in 1..16: latch load_len, set counter = 0, go to HI.
    - load_start with load_len = 0 or > 16: err pulses for 1 cycle, stay in IDLE.
  - HI: on an accepted byte, store it as word[15:8] and go to LO.
  - LO: on an accepted byte, on the same edge write mem[counter] = {hi, byte}.
    - If counter == len-1: go to DONE.
    - Otherwise: counter += 1 and go to HI.
  - DONE: done = 1 for exactly this cycle, then go to IDLE unconditionally.
- busy = 1 in HI, LO and DONE. Words at index >= len keep their previous contents.
- load_start while busy is ignored, with no err.
- load_abort in HI or LO:
  - Go to IDLE next edge and pulse err for 1 cycle.
  - Words already written are retained; a pending high byte is discarded.
  - Abort takes priority over a byte accepted on the same edge: that byte is not written.
  - Abort in IDLE or DONE has no effect.
- Fetch port (combinational):
  - If busy: instruction = 16'h0000.
  - Else if pc < 2*DEPTH: instruction = mem[pc[ADDR_W:1]]. pc[0] is ignored.
  - Else: instruction = 16'h0000.
  - A write on edge N is visible on instruction after edge N, once busy has deasserted.
- Latency: a load of L words takes at least 2L+1 cycles from first acceptance to busy falling (2L byte-accept cycles, then 1 DONE cycle). in_valid gaps stretch this arbitrarily; the FSM simply waits in HI or LO.
- Reset mid-load: clears the FSM and memory immediately, independent of clk. No done or err is produced.

Test Plan:
- Reset then idle: assert rst, release; pc = 0, 2, 30 -> instruction = 16'h0000; busy = 0; in_ready = 0.
- Two-word load, in_valid held high: load_len = 2, bytes 8'h80 8'h80 8'hE1 8'h01 -> done pulses once on the cycle after the 4th acceptance. Then pc = 0 -> 16'h8080 and pc = 2 -> 16'hE101; pc = 4 -> 16'h0000.
- Back-pressure: in_valid toggled 1/0 every cycle during a load_len = 1 load of 8'hC0 8'h7A -> no byte duplicated or dropped; mem[0] = 16'hC07A; busy high throughout, with instruction = 0 while busy.
- Full-depth and range:
  - load_len = 16 with words 16'h0100 + i -> pc = 30 gives 16'h010F.
  - pc = 32 -> 16'h0000.
  - A second load with load_len = 1 of 16'hFFFF leaves word 1 = 16'h0101.
- Illegal start and ignored start: load_len = 0 -> err for 1 cycle, busy stays 0. load_len = 17 -> err. load_start pulsed mid-load -> no effect; the original load completes.
- Abort and reset mid-load:
  - load_len = 3, abort after 3 bytes -> err pulses, mem[0] written, mem[1] unchanged, busy drops.
  - Repeat with rst asserted between clock edges -> all outputs 0 immediately and all words read 16'h0000.
